// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared bomb game types, button codes and key helper
package bomb_pkg;

  localparam int SEQ_LEN = 8;
  localparam logic [3:0] BTN_EMPTY = 4'hF;

  localparam logic [2:0] LEFT  = 3'd0;
  localparam logic [2:0] RIGHT = 3'd1;
  localparam logic [2:0] UP    = 3'd2;
  localparam logic [2:0] DOWN  = 3'd3;
  localparam logic [2:0] A     = 3'd4;
  localparam logic [2:0] B     = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTRY    = 2'd1,
    DEFUSED  = 2'd2,
    EXPLODED = 2'd3
  } state_t;

  function automatic logic [3:0] key_entry(input logic [31:0] k, input logic [2:0] idx);
    return k[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/btn_event.sv
// rtl/btn_event.sv - press edge detector with lowest-index priority encoder
module btn_event
  import bomb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] btn,
  output logic       press,
  output logic [2:0] code
);

  logic [5:0] btn_q;
  logic [5:0] btn_q_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q   <= '0;
      btn_q_d <= '0;
    end else begin
      btn_q   <= btn;
      btn_q_d <= btn_q;
    end
  end

  // A press only counts after a full cycle with every button released.
  assign press = (btn_q != '0) && (btn_q_d == '0);

  always_comb begin
    code = LEFT;
    for (int i = 5; i >= 0; i--) begin
      if (btn_q[i]) code = 3'(i);
    end
  end

endmodule

// File: rtl/bomb_sequencer.sv
// rtl/bomb_sequencer.sv - bomb game FSM, entry history and countdown timer
module bomb_sequencer
  import bomb_pkg::*;
#(
  parameter int TICK_DIV  = 25_000_000,
  parameter int TIMEOUT_S = 60
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [5:0]  btn,
  input  logic [31:0] key,
  output logic [3:0]  buttons [0:SEQ_LEN-1],
  output logic [1:0]  state,
  output logic [7:0]  seconds_left,
  output logic [3:0]  count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_S);

  logic          press;
  logic [2:0]    code;
  logic [3:0]    code_w;
  state_t        state_q;
  logic [PW-1:0] presc;

  btn_event u_btn_event (
    .clk   (vga_clk),
    .rst   (rst),
    .btn   (btn),
    .press (press),
    .code  (code)
  );

  assign code_w = {1'b0, code};
  assign state  = state_q;

  always_ff @(posedge vga_clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      count        <= '0;
      seconds_left <= TIMEOUT_V;
      presc        <= '0;
      for (int i = 0; i < SEQ_LEN; i++) buttons[i] <= BTN_EMPTY;
    end else begin
      case (state_q)
        IDLE: begin
          seconds_left <= TIMEOUT_V;
          presc        <= '0;
          if (press) begin
            buttons[0] <= code_w;
            count      <= 4'd1;
            state_q    <= (code_w == key_entry(key, 3'd0)) ? ENTRY : EXPLODED;
          end
        end

        ENTRY: begin
          if (presc == PRESC_MAX) begin
            presc <= '0;
            if (seconds_left != 8'd0) seconds_left <= seconds_left - 8'd1;
          end else begin
            presc <= presc + PW'(1);
          end

          // A press in the expiry cycle is judged before the timeout.
          if (press) begin
            if (count < 4'(SEQ_LEN)) begin
              buttons[count[2:0]] <= code_w;
              count               <= count + 4'd1;
            end
            if (code_w != key_entry(key, count[2:0]))
              state_q <= EXPLODED;
            else if (count == 4'(SEQ_LEN - 1))
              state_q <= DEFUSED;
            else if (seconds_left == 8'd0)
              state_q <= EXPLODED;
          end else if (seconds_left == 8'd0) begin
            state_q <= EXPLODED;
          end
        end

        default: begin
          if (press) begin
            state_q      <= IDLE;
            count        <= '0;
            seconds_left <= TIMEOUT_V;
            presc        <= '0;
            for (int i = 0; i < SEQ_LEN; i++) buttons[i] <= BTN_EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_sequencer.sv
// tb/tb_bomb_sequencer.sv - self-checking bench for bomb_sequencer
module tb_bomb_sequencer;
  import bomb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  btn;
  logic [31:0] key;

  logic [3:0] buttons_m [0:7];
  logic [1:0] state_m;
  logic [7:0] sec_m;
  logic [3:0] count_m;

  logic [3:0] buttons_t [0:7];
  logic [1:0] state_t_o;
  logic [7:0] sec_t;
  logic [3:0] count_t;

  always #5 clk = ~clk;

  bomb_sequencer #(.TICK_DIV(10), .TIMEOUT_S(100)) dut_m (
    .vga_clk(clk), .rst(rst), .btn(btn), .key(key),
    .buttons(buttons_m), .state(state_m), .seconds_left(sec_m), .count(count_m)
  );

  bomb_sequencer #(.TICK_DIV(4), .TIMEOUT_S(3)) dut_t (
    .vga_clk(clk), .rst(rst), .btn(btn), .key(key),
    .buttons(buttons_t), .state(state_t_o), .seconds_left(sec_t), .count(count_t)
  );

  typedef struct {
    logic [2:0] code;
    logic [1:0] st;
    logic [3:0] cnt;
    int         slot;
    logic [3:0] val;
  } vec_t;

  vec_t vecs [13];
  vec_t exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_main_reset(input string tag);
    chk({tag, " state"}, int'(state_m), 0);
    chk({tag, " count"}, int'(count_m), 0);
    chk({tag, " seconds"}, int'(sec_m), 100);
    for (int i = 0; i < 8; i++) chk($sformatf("%s slot%0d", tag, i), int'(buttons_m[i]), 15);
  endtask

  // Drives a press and returns just after the edge that acts on it.
  task automatic press_code(input logic [2:0] c);
    @(negedge clk);
    btn = 6'b000001 << c;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    rst = 1'b0;
    btn = '0;
    key = 32'h5432_1032;

    vecs[0]  = '{3'd2, 2'd1, 4'd1, 0, 4'h2};
    vecs[1]  = '{3'd3, 2'd1, 4'd2, 1, 4'h3};
    vecs[2]  = '{3'd0, 2'd1, 4'd3, 2, 4'h0};
    vecs[3]  = '{3'd1, 2'd1, 4'd4, 3, 4'h1};
    vecs[4]  = '{3'd2, 2'd1, 4'd5, 4, 4'h2};
    vecs[5]  = '{3'd3, 2'd1, 4'd6, 5, 4'h3};
    vecs[6]  = '{3'd4, 2'd1, 4'd7, 6, 4'h4};
    vecs[7]  = '{3'd5, 2'd2, 4'd8, 7, 4'h5};
    vecs[8]  = '{3'd0, 2'd0, 4'd0, 0, 4'hF};
    vecs[9]  = '{3'd2, 2'd1, 4'd1, 0, 4'h2};
    vecs[10] = '{3'd3, 2'd1, 4'd2, 1, 4'h3};
    vecs[11] = '{3'd1, 2'd3, 4'd3, 2, 4'h1};
    vecs[12] = '{3'd4, 2'd0, 4'd0, 2, 4'hF};

    // reset and idle
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_main_reset("reset");
    chk("reset t seconds", int'(sec_t), 3);
    repeat (100) @(negedge clk);
    chk_main_reset("idle100");

    // timeout on the fast-ticking instance
    press_code(3'd2);
    chk("to entry state", int'(state_t_o), 1);
    chk("to entry seconds", int'(sec_t), 3);
    btn = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("to seconds k%0d", k), int'(sec_t), (k < 12) ? (3 - k / 4) : 0);
      chk($sformatf("to state k%0d", k), int'(state_t_o), (k <= 12) ? 1 : 3);
    end
    chk("to count frozen", int'(count_t), 1);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_main_reset("reset2");

    // correct code, then wrong code, through the scoreboard
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(vecs[i]);
      press_code(vecs[i].code);
      v = exp_q.pop_front();
      chk($sformatf("row%0d state", i), int'(state_m), int'(v.st));
      chk($sformatf("row%0d count", i), int'(count_m), int'(v.cnt));
      chk($sformatf("row%0d slot%0d", i, v.slot), int'(buttons_m[v.slot]), int'(v.val));
      btn = '0;
      if (v.st == 2'd0) chk_main_reset($sformatf("row%0d idle", i));
      if (i == 7) begin
        repeat (20) @(negedge clk);
        chk("defused frozen state", int'(state_m), 2);
        chk("defused frozen count", int'(count_m), 8);
        chk("defused frozen seconds", int'(sec_m), 98);
        chk("defused frozen slot7", int'(buttons_m[7]), 5);
      end
      if (i == 11) begin
        for (int s = 3; s < 8; s++) chk($sformatf("exploded slot%0d", s), int'(buttons_m[s]), 15);
      end
    end

    // press rules: hold, change without release, release and press
    @(negedge clk);
    btn = 6'b010100;
    repeat (10) @(negedge clk);
    chk("hold count", int'(count_m), 1);
    chk("hold slot0", int'(buttons_m[0]), 2);
    chk("hold state", int'(state_m), 1);
    btn = 6'b000001;
    repeat (5) @(negedge clk);
    chk("noreleased count", int'(count_m), 1);
    chk("noreleased slot1", int'(buttons_m[1]), 15);
    btn = '0;
    press_code(3'd3);
    chk("after release count", int'(count_m), 2);
    chk("after release slot1", int'(buttons_m[1]), 3);
    btn = '0;
    press_code(3'd0);
    btn = '0;
    press_code(3'd1);
    btn = '0;
    press_code(3'd2);
    btn = '0;
    chk("five count", int'(count_m), 5);
    chk("five state", int'(state_m), 1);
    chk("five slot4", int'(buttons_m[4]), 2);

    // reset in the middle of entry
    rst = 1'b0;
    @(negedge clk);
    chk_main_reset("midreset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bomb_sequencer.md
Name: bomb_sequencer

Overview:
- Game controller that produces the `buttons` history and 2-bit `state` consumed by the VGA display path.
- Detects button presses and records the last 8 codes in an entry buffer.
- Compares the entries against an 8-code key and runs a countdown timer.
- Sequences the bomb through IDLE / ENTRY / DEFUSED / EXPLODED.
- Runs entirely in the vga_clk domain, so its outputs feed the display without crossing clocks.

Parameters:
SEQ_LEN, 8, number of code entries (fixed 8 to match the display; other values unsupported)
TICK_DIV, 25_000_000, vga_clk cycles per countdown second
TIMEOUT_S, 60, initial seconds on countdown (1..255)

Ports:
vga_clk  input  1  system clock (pixel clock)
rst  input  1  synchronous reset, active-low: all registers reset on a vga_clk edge while rst==0
btn  input  6  button levels, already synchronised and debounced, bit i = code i (LEFT=0, RIGHT=1, UP=2, DOWN=3, A=4, B=5)
key  input  32  target code, entry i = key[4i+3:4i]; treated as static during ENTRY
buttons  output  4x[0:7]  entry history to display, entry i = i-th accepted press; 4'hF = empty slot
state  output  2  0=IDLE, 1=ENTRY, 2=DEFUSED, 3=EXPLODED
seconds_left  output  8  countdown value for display
count  output  4  number of entries accepted (0..8)

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE, all buttons entries=4'hF, count=0, seconds_left=TIMEOUT_S.
  - Prescaler=0, internal btn_q/btn_q_d=0.
  - Reset mid-game discards all progress.
- Press detection:
  - btn is registered into btn_q; btn_q is registered into btn_q_d.
  - Press event = (btn_q != 0) && (btn_q_d == 0).
  - A new press requires all buttons released for at least one cycle between presses.
  - If several bits are high in btn_q at the event, the lowest index wins; the others are ignored.
  - Holding a button produces exactly one event.
  - Latency: btn first sampled high at edge E0 -> event evaluated and outputs updated at edge E1.
- IDLE:
  - seconds_left held at TIMEOUT_S.
  - A press writes its code to buttons[0], sets count=1, and moves to ENTRY.
  - If that code != key entry 0, the state goes to EXPLODED instead.
- ENTRY:
  - Each press writes its code to buttons[count] and increments count.
  - If the code != key entry count (pre-increment index), next state = EXPLODED.
  - Otherwise, if count reaches SEQ_LEN, next state = DEFUSED; otherwise remain in ENTRY.
  - Countdown: the prescaler counts 0..TICK_DIV-1; on wrap, seconds_left decrements.
  - When seconds_left==0 in ENTRY -> EXPLODED on the next edge; seconds_left never underflows.
  - Prescaler starts from 0 on the IDLE->ENTRY transition.
- Simultaneous press and timeout expiry in the same cycle:
  - The press is evaluated first.
  - A correct final entry -> DEFUSED; anything else -> EXPLODED.
- DEFUSED / EXPLODED (terminal):
  - buttons, count and seconds_left are frozen; the prescaler stops.
  - Any press event returns to IDLE, clears entries to 4'hF, sets count=0 and seconds_left=TIMEOUT_S.
  - That press is not recorded.
- Width rules:
  - Prescaler width = $clog2(TICK_DIV).
  - count saturates at SEQ_LEN.
  - No write beyond index 7 under any sequence.
- All outputs are registered; there is no combinational path from btn or key to outputs.

Decomposition:
- Shared package bomb_pkg holds:
  - state enum: IDLE, ENTRY, DEFUSED, EXPLODED.
  - button code localparams (LEFT..B, 3'd0..3'd5).
  - BTN_EMPTY = 4'hF.
  - SEQ_LEN.
- These replace the per-module localparams currently duplicated in the display controllers.
- One sub-module: btn_event. It contains the btn_q/btn_q_d registers, the release check and the lowest-index priority encoder, and outputs event plus a 3-bit code.
- The FSM, history buffer and timer stay in bomb_sequencer.

Test Plan:
1. Reset then idle: hold rst=0 for 2 cycles, release -> state=0, all buttons=4'hF, count=0, seconds_left=TIMEOUT_S, unchanged after 100 idle cycles.
2. Correct code: key=32'h54321032, press codes 2,3,0,1,2,3,4,5 with releases between -> buttons[0..7]=2,3,0,1,2,3,4,5, state=DEFUSED one edge after the 8th event, count=8.
3. Wrong entry: same key, press 2,3,1 -> state=EXPLODED at the 3rd event, buttons[2]=1, buttons[3..7]=4'hF, further presses -> IDLE with cleared history.
4. Timeout: TICK_DIV=4, TIMEOUT_S=3, one correct press, then idle -> seconds_left 3->2->1->0 every 4 cycles, state=EXPLODED on the edge after reaching 0.
5. Press rules: btn=6'b010100 held 10 cycles -> exactly one entry of code 2. Then btn changes to 6'b000001 without release -> no entry. Release, then press -> entry accepted.
6. Reset mid-ENTRY after 5 correct presses: rst=0 for 1 cycle -> all outputs return to reset values on that edge.
